id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of operands, PC, instruction and immediate.
REQ-002 Parameter NREG, default 32, register count; RA = clog2(NREG) register-address width.
REQ-003 Parameter FWD_EN, default 1, 1 = EX/MEM forwarding enabled, 0 = regfile/WB path only.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 hold, flush  in  1 each  stall (keep EX registers) / squash (load bubble).
REQ-007 inst_id, pc_id  in  XLEN each  decoded instruction and its PC; valid_id  in  1  instruction valid.
REQ-008 imm_sel  in  4  immediate format select, passed to imm_gen.
REQ-009 wb_we  in  1, wb_rd  in  RA, wb_din  in  XLEN  writeback port.
REQ-010 ex_we, ex_is_load  in  1 each, ex_rd  in  RA, ex_result  in  XLEN  EX-stage producer.
REQ-011 mem_we  in  1, mem_rd  in  RA, mem_result  in  XLEN  MEM-stage producer.
REQ-012 inst_ex, pc_ex, d1, d2, imm_ex  out  XLEN each; valid_ex  out  1  registered EX-stage bundle.
REQ-013 stall_req  out  1  combinational load-use stall request to IF/ID.

Function
REQ-014 rs1 = inst_id[19:15], rs2 = inst_id[24:20], truncated to RA bits.
REQ-015 Register file: 2 read ports combinational, 1 write port at clk edge when wb_we and wb_rd != 0; x0 always reads 0.
REQ-016 Operand source priority per rs: rs = 0 -> 0; ex_we, ex_rd = rs, !ex_is_load, FWD_EN -> ex_result; mem_we, mem_rd = rs, FWD_EN -> mem_result; wb_we, wb_rd = rs -> wb_din (same-cycle bypass); else regfile.
REQ-017 stall_req = valid_id and ex_we and ex_is_load and ex_rd != 0 and (ex_rd = rs1 or ex_rd = rs2); rs2 match is counted for all opcodes (conservative).
REQ-018 With FWD_EN = 0, stall_req also asserts on any ex_we or mem_we rd match (nonzero), covering all RAW hazards except WB.
REQ-019 Register update priority at clk edge: rst > flush > hold > stall_req > normal.
REQ-020 flush or stall_req: inst_ex = NOP (32'h0000_0013, zero-extended to XLEN), pc_ex/d1/d2/imm_ex = 0, valid_ex = 0.
REQ-021 hold (no flush/rst): all EX outputs retain value; regfile write still occurs.
REQ-022 Normal: EX outputs take inst_id, pc_id, selected operands, imm, valid_id; latency 1 cycle.
REQ-023 valid_id = 0: bundle still captured, valid_ex = 0, stall_req = 0.
REQ-024 hold with stall_req simultaneous: hold wins, registers retain; stall_req still output.

Reset
REQ-025 On rst sampled high at clk edge: inst_ex = NOP, pc_ex/d1/d2/imm_ex = 0, valid_ex = 0.
REQ-026 On rst, all regfile entries clear to 0; a wb write in the same cycle is discarded.
REQ-027 rst mid-stall or mid-hold overrides; first post-reset cycle behaves as normal.

Structure
REQ-028 Shared package holds NOP constant, imm_sel encodings, RS1/RS2 field positions.
REQ-029 One sub-module reg_file (parametrised XLEN, NREG, sync reset); immediate via existing imm_gen instance.

Verification
REQ-030 WB bypass: wb_we=1, wb_rd=5, wb_din=0xDEAD_BEEF, inst_id rs1=5 -> next cycle d1 = 0xDEAD_BEEF.
REQ-031 Forward priority: ex_rd=mem_rd=wb_rd=3 (results 0x11/0x22/0x33), rs2=3 -> d2 = 0x11; ex_we=0 -> 0x22; FWD_EN=0 -> 0x33 and stall_req=1 while ex/mem match.
REQ-032 Load-use: ex_is_load=1, ex_rd=7, rs1=7, valid_id=1 -> stall_req=1, next valid_ex=0, inst_ex=0x13; ex_rd=0 -> stall_req=0.
REQ-033 Hold/flush: hold 3 cycles -> outputs constant; flush with hold -> bubble; x0 write of 0x55 -> rs1=0 reads 0.
REQ-034 Reset mid-operation: regfile loaded, rst pulse 1 cycle -> all outputs reset values, r1..r31 read 0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: bubble instruction, immediate formats,
// and register-specifier field positions.
package id_ex_stage_pkg;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  typedef enum logic [3:0] {
    IMM_I = 4'd0,
    IMM_S = 4'd1,
    IMM_B = 4'd2,
    IMM_U = 4'd3,
    IMM_J = 4'd4
  } imm_sel_e;
endpackage

// File: rtl/id_ex_stage_reg_file.sv
// Register file: two combinational read ports, one clocked write port,
// synchronous clear. Entry 0 is never written so it always reads zero.
module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int RA  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [RA-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RA-1:0]   raddr1,
  input  logic [RA-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);
  logic [NREG-1:0][XLEN-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we && waddr != '0) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  assign rdata1 = mem_q[raddr1];
  assign rdata2 = mem_q[raddr2];
endmodule

// File: rtl/imm_gen.sv
// RISC-V immediate generator: extracts and sign-extends the immediate for the
// selected instruction format.
module imm_gen
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  logic [3:0]      imm_sel,
  output logic [XLEN-1:0] imm
);
  logic [31:0] imm32;
  logic        unused_opcode;

  assign unused_opcode = ^inst[6:0];

  always_comb begin
    imm32 = '0;
    case (imm_sel)
      IMM_I: imm32 = 32'($signed(inst[31:20]));
      IMM_S: imm32 = 32'($signed({inst[31:25], inst[11:7]}));
      IMM_B: imm32 = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      IMM_U: imm32 = {inst[31:12], 12'h000};
      IMM_J: imm32 = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: operand read with EX/MEM/WB bypass, load-use stall
// detection, immediate generation and the registered EX-stage bundle.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int FWD_EN = 1,
  localparam int RA    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            flush,
  input  logic [XLEN-1:0] inst_id,
  input  logic [XLEN-1:0] pc_id,
  input  logic            valid_id,
  input  logic [3:0]      imm_sel,
  input  logic            wb_we,
  input  logic [RA-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_din,
  input  logic            ex_we,
  input  logic            ex_is_load,
  input  logic [RA-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_result,
  input  logic            mem_we,
  input  logic [RA-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_result,
  output logic [XLEN-1:0] inst_ex,
  output logic [XLEN-1:0] pc_ex,
  output logic [XLEN-1:0] d1,
  output logic [XLEN-1:0] d2,
  output logic [XLEN-1:0] imm_ex,
  output logic            valid_ex,
  output logic            stall_req
);
  localparam logic [XLEN-1:0] NOP_X = XLEN'(NOP_INST);

  logic [1:0][RA-1:0]   rs;
  logic [1:0][XLEN-1:0] rf_rd, opnd;
  logic [1:0]           ex_hit, mem_hit;
  logic [XLEN-1:0]      imm_id;
  logic                 load_use, raw_nofwd;

  logic [XLEN-1:0] inst_ex_q, inst_ex_d, pc_ex_q, pc_ex_d;
  logic [XLEN-1:0] d1_q, d1_d, d2_q, d2_d, imm_ex_q, imm_ex_d;
  logic            valid_ex_q, valid_ex_d;

  assign rs[0] = inst_id[RS1_LSB +: RA];
  assign rs[1] = inst_id[RS2_LSB +: RA];

  reg_file #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (wb_din),
    .raddr1 (rs[0]),
    .raddr2 (rs[1]),
    .rdata1 (rf_rd[0]),
    .rdata2 (rf_rd[1])
  );

  imm_gen #(.XLEN(XLEN)) u_imm (
    .inst    (inst_id[31:0]),
    .imm_sel (imm_sel),
    .imm     (imm_id)
  );

  // Per-port source select: x0, then youngest producer first.
  always_comb begin
    opnd    = '0;
    ex_hit  = '0;
    mem_hit = '0;
    for (int p = 0; p < 2; p++) begin
      ex_hit[p]  = ex_we  && ex_rd  != '0 && ex_rd  == rs[p];
      mem_hit[p] = mem_we && mem_rd != '0 && mem_rd == rs[p];
      if (rs[p] == '0)                                 opnd[p] = '0;
      else if (FWD_EN != 0 && ex_hit[p] && !ex_is_load) opnd[p] = ex_result;
      else if (FWD_EN != 0 && mem_hit[p])               opnd[p] = mem_result;
      else if (wb_we && wb_rd == rs[p])                 opnd[p] = wb_din;
      else                                              opnd[p] = rf_rd[p];
    end
  end

  // rs2 is matched for every opcode; an occasional needless stall is cheaper than decoding.
  assign load_use  = ex_is_load && |ex_hit;
  assign raw_nofwd = (FWD_EN == 0) && (|ex_hit || |mem_hit);
  assign stall_req = valid_id && (load_use || raw_nofwd);

  always_comb begin
    inst_ex_d  = inst_ex_q;
    pc_ex_d    = pc_ex_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    imm_ex_d   = imm_ex_q;
    valid_ex_d = valid_ex_q;
    if (flush || (!hold && stall_req)) begin
      inst_ex_d  = NOP_X;
      pc_ex_d    = '0;
      d1_d       = '0;
      d2_d       = '0;
      imm_ex_d   = '0;
      valid_ex_d = 1'b0;
    end else if (!hold) begin
      inst_ex_d  = inst_id;
      pc_ex_d    = pc_id;
      d1_d       = opnd[0];
      d2_d       = opnd[1];
      imm_ex_d   = imm_id;
      valid_ex_d = valid_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_ex_q  <= NOP_X;
      pc_ex_q    <= '0;
      d1_q       <= '0;
      d2_q       <= '0;
      imm_ex_q   <= '0;
      valid_ex_q <= 1'b0;
    end else begin
      inst_ex_q  <= inst_ex_d;
      pc_ex_q    <= pc_ex_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      imm_ex_q   <= imm_ex_d;
      valid_ex_q <= valid_ex_d;
    end
  end

  assign inst_ex  = inst_ex_q;
  assign pc_ex    = pc_ex_q;
  assign d1       = d1_q;
  assign d2       = d2_q;
  assign imm_ex   = imm_ex_q;
  assign valid_ex = valid_ex_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a forwarding instance and a no-forwarding
// instance share stimulus; expected EX bundles are queued and checked by a monitor.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, hold, flush, valid_id, wb_we, ex_we, ex_is_load, mem_we;
  logic [31:0] inst_id, pc_id, wb_din, ex_result, mem_result;
  logic [3:0]  imm_sel;
  logic [4:0]  wb_rd, ex_rd, mem_rd;

  logic [1:0][31:0] inst_ex, pc_ex, d1, d2, imm_ex;
  logic [1:0]       valid_ex, stall_req;

  id_ex_stage #(.XLEN(32), .NREG(32), .FWD_EN(1)) dut0 (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .inst_id(inst_id), .pc_id(pc_id),
    .valid_id(valid_id), .imm_sel(imm_sel), .wb_we(wb_we), .wb_rd(wb_rd), .wb_din(wb_din),
    .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_result(mem_result),
    .inst_ex(inst_ex[0]), .pc_ex(pc_ex[0]), .d1(d1[0]), .d2(d2[0]), .imm_ex(imm_ex[0]),
    .valid_ex(valid_ex[0]), .stall_req(stall_req[0])
  );

  id_ex_stage #(.XLEN(32), .NREG(32), .FWD_EN(0)) dut1 (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .inst_id(inst_id), .pc_id(pc_id),
    .valid_id(valid_id), .imm_sel(imm_sel), .wb_we(wb_we), .wb_rd(wb_rd), .wb_din(wb_din),
    .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_result(mem_result),
    .inst_ex(inst_ex[1]), .pc_ex(pc_ex[1]), .d1(d1[1]), .d2(d2[1]), .imm_ex(imm_ex[1]),
    .valid_ex(valid_ex[1]), .stall_req(stall_req[1])
  );

  typedef struct {
    int          cyc;
    int          dut;
    string       name;
    logic [31:0] inst, pc, d1, d2, imm;
    logic        valid;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every bundle due on this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      checks++;
      if ({inst_ex[e.dut], pc_ex[e.dut], d1[e.dut], d2[e.dut], imm_ex[e.dut], valid_ex[e.dut]} !==
          {e.inst, e.pc, e.d1, e.d2, e.imm, e.valid}) begin
        errors++;
        $display("FAIL %s dut%0d: got inst=%h pc=%h d1=%h d2=%h imm=%h v=%b want inst=%h pc=%h d1=%h d2=%h imm=%h v=%b",
                 e.name, e.dut, inst_ex[e.dut], pc_ex[e.dut], d1[e.dut], d2[e.dut], imm_ex[e.dut],
                 valid_ex[e.dut], e.inst, e.pc, e.d1, e.d2, e.imm, e.valid);
      end
    end
  end

  function automatic logic [31:0] mk(input logic [4:0] r1, input logic [4:0] r2);
    return {7'h00, r2, r1, 3'b000, 5'd1, 7'h33};
  endfunction

  task automatic push(input int dut, input string name, input logic [31:0] d1v, d2v, immv,
                      input logic v);
    exp_t x;
    x = '{cyc + 1, dut, name, inst_id, pc_id, d1v, d2v, immv, v};
    q.push_back(x);
  endtask

  task automatic bubble(input int dut, input string name);
    exp_t x;
    x = '{cyc + 1, dut, name, NOP_INST, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
    q.push_back(x);
  endtask

  task automatic chk_stall(input int dut, input string name, input logic want);
    checks++;
    if (stall_req[dut] !== want) begin
      errors++;
      $display("FAIL %s dut%0d: stall_req got %b want %b", name, dut, stall_req[dut], want);
    end
  endtask

  task automatic idle();
    rst = 0; hold = 0; flush = 0; valid_id = 1; imm_sel = IMM_I;
    wb_we = 0; wb_rd = 0; wb_din = 0;
    ex_we = 0; ex_is_load = 0; ex_rd = 0; ex_result = 0;
    mem_we = 0; mem_rd = 0; mem_result = 0;
    inst_id = mk(0, 0); pc_id = 0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    idle();
    // reset with a concurrent write that must be discarded
    rst = 1; wb_we = 1; wb_rd = 4; wb_din = 32'h99;
    bubble(0, "reset"); bubble(1, "reset");
    step();

    idle(); wb_we = 1; wb_rd = 5; wb_din = 32'hDEAD_BEEF; inst_id = mk(5, 4); pc_id = 32'h100;
    push(0, "wb_bypass", 32'hDEAD_BEEF, 32'h0, 32'd4, 1);
    push(1, "wb_bypass", 32'hDEAD_BEEF, 32'h0, 32'd4, 1);
    step();

    idle(); inst_id = mk(5, 0); pc_id = 32'h104;
    push(0, "rf_read", 32'hDEAD_BEEF, 32'h0, 32'h0, 1);
    push(1, "rf_read", 32'hDEAD_BEEF, 32'h0, 32'h0, 1);
    step();

    idle(); ex_we = 1; ex_rd = 3; ex_result = 32'h11; mem_we = 1; mem_rd = 3; mem_result = 32'h22;
    wb_we = 1; wb_rd = 3; wb_din = 32'h33; inst_id = mk(0, 3); pc_id = 32'h108;
    push(0, "fwd_ex", 32'h0, 32'h11, 32'd3, 1);
    bubble(1, "nofwd_ex");
    #1 chk_stall(0, "fwd_ex", 0); chk_stall(1, "nofwd_ex", 1);
    step();

    ex_we = 0; pc_id = 32'h10C;
    push(0, "fwd_mem", 32'h0, 32'h22, 32'd3, 1);
    bubble(1, "nofwd_mem");
    #1 chk_stall(0, "fwd_mem", 0); chk_stall(1, "nofwd_mem", 1);
    step();

    mem_we = 0; pc_id = 32'h110;
    push(0, "fwd_wb", 32'h0, 32'h33, 32'd3, 1);
    push(1, "nofwd_wb", 32'h0, 32'h33, 32'd3, 1);
    #1 chk_stall(1, "nofwd_wb", 0);
    step();

    idle(); ex_we = 1; ex_is_load = 1; ex_rd = 7; ex_result = 32'h77; inst_id = mk(7, 0);
    pc_id = 32'h114;
    bubble(0, "load_use"); bubble(1, "load_use");
    #1 chk_stall(0, "load_use", 1); chk_stall(1, "load_use", 1);
    step();

    ex_rd = 0; inst_id = mk(0, 5); pc_id = 32'h118;
    push(0, "load_rd0", 32'h0, 32'hDEAD_BEEF, 32'd5, 1);
    push(1, "load_rd0", 32'h0, 32'hDEAD_BEEF, 32'd5, 1);
    #1 chk_stall(0, "load_rd0", 0); chk_stall(1, "load_rd0", 0);
    step();

    ex_rd = 7; inst_id = mk(7, 3); valid_id = 0; pc_id = 32'h11C;
    push(0, "invalid_id", 32'h0, 32'h33, 32'd3, 0);
    push(1, "invalid_id", 32'h0, 32'h33, 32'd3, 0);
    #1 chk_stall(0, "invalid_id", 0); chk_stall(1, "invalid_id", 0);
    step();

    idle(); inst_id = mk(5, 3); pc_id = 32'h200;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        hold = 1; inst_id = mk(1, 2); pc_id = 32'h300; wb_we = 1; wb_rd = 6; wb_din = 32'h66;
      end else if (i == 2) begin
        wb_we = 0; inst_id = mk(5, 1); pc_id = 32'h304; ex_we = 1; ex_is_load = 1; ex_rd = 5;
      end else if (i == 3) begin
        ex_we = 0; ex_is_load = 0; ex_rd = 0;
      end
      q.push_back('{cyc + 1, 0, "hold_keep", mk(5, 3), 32'h200, 32'hDEAD_BEEF, 32'h33, 32'd3, 1'b1});
      if (i == 2) begin
        #1 chk_stall(0, "hold_stall", 1);
      end
      step();
    end

    flush = 1;
    bubble(0, "flush_hold");
    step();

    idle(); inst_id = mk(6, 0); pc_id = 32'h208;
    push(0, "write_in_hold", 32'h66, 32'h0, 32'h0, 1);
    step();

    idle(); wb_we = 1; wb_rd = 0; wb_din = 32'h55; inst_id = mk(0, 0); pc_id = 32'h20C;
    push(0, "x0_wb", 32'h0, 32'h0, 32'h0, 1);
    step();

    idle(); pc_id = 32'h210;
    push(0, "x0_read", 32'h0, 32'h0, 32'h0, 1);
    step();

    idle(); imm_sel = IMM_S; inst_id = 32'hFE11_2E23; pc_id = 32'h214;
    push(0, "imm_s", 32'h0, 32'h0, 32'hFFFF_FFFC, 1);
    step();

    idle(); imm_sel = IMM_U; inst_id = 32'h1234_5037; pc_id = 32'h218;
    push(0, "imm_u", 32'h0, 32'h33, 32'h1234_5000, 1);
    step();

    idle(); inst_id = 32'hFFF0_0093; pc_id = 32'h21C;
    push(0, "imm_i_neg", 32'h0, 32'h0, 32'hFFFF_FFFF, 1);
    step();

    idle(); rst = 1; hold = 1; ex_we = 1; ex_is_load = 1; ex_rd = 5; inst_id = mk(5, 0);
    pc_id = 32'h220;
    bubble(0, "rst_mid_hold"); bubble(1, "rst_mid_hold");
    step();

    for (int i = 1; i < 32; i++) begin
      idle(); inst_id = mk(5'(i), 5'(i)); pc_id = 32'h400 + 32'(4 * i);
      push(0, "post_rst_rd", 32'h0, 32'h0, 32'(i), 1);
      step();
    end

    idle(); valid_id = 0;
    repeat (3) step();
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expected bundles left unchecked, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
